// File: rtl/tx10_pkg.sv
// Shared types and sizing for the tx10 BCD display path.
// Constants describe the default temperature word and display width.
package tx10_pkg;

    localparam int TX10_W       = 17;
    localparam int TX10_FRAC    = 4;
    localparam int BCD_DIGITS   = 4;
    localparam int SHIFT_CYCLES = TX10_W - TX10_FRAC;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/tx10_bcd_display.sv
// Iterative signed tx10 to sign + BCD digits converter (round, then shift-add-3).
// One bit of the rounded magnitude is consumed per SHIFT cycle.
module tx10_bcd_display
    import tx10_pkg::*;
#(
    parameter int WIDTH_IN  = TX10_W,
    parameter int FRAC_BITS = TX10_FRAC,
    parameter int DIGITS    = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH_IN-1:0] tx10,
    output logic                busy,
    output logic                done,
    output logic                neg,
    output logic [3:0]          d3,
    output logic [3:0]          d2,
    output logic [3:0]          d1,
    output logic [3:0]          d0
);

    localparam int VAL_W = WIDTH_IN - FRAC_BITS;
    localparam int MAG_W = WIDTH_IN + 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VAL_W);

    state_t state, state_nxt;

    logic [WIDTH_IN-1:0]    cap;
    logic                   sign;
    logic                   nz;
    logic [VAL_W-1:0]       val;
    logic [BCD_W-1:0]       bcd;
    logic [CNT_W-1:0]       cnt;
    logic                   neg_q;
    logic [BCD_W-1:0]       dig_q;

    logic [MAG_W-1:0]       mag;
    logic [MAG_W-1:0]       rnd;
    logic [VAL_W-1:0]       val_ld;
    logic [BCD_W-1:0]       bcd_corr;
    logic [BCD_W+VAL_W-1:0] sh_all;
    logic [BCD_W-1:0]       bcd_sh;
    logic [VAL_W-1:0]       val_sh;
    logic                   last_shift;

    // Magnitude is one bit wider so the most negative input does not wrap.
    assign mag = cap[WIDTH_IN-1] ? (MAG_W'(0) - {cap[WIDTH_IN-1], cap})
                                 : {1'b0, cap};
    assign rnd = (mag + MAG_W'(1 << (FRAC_BITS - 1))) >> FRAC_BITS;
    assign val_ld = (rnd > MAG_W'((1 << VAL_W) - 1)) ? '1 : rnd[VAL_W-1:0];

    bcd_add3 u_add3 [DIGITS-1:0] (
        .din  (bcd),
        .dout (bcd_corr)
    );

    assign sh_all     = {bcd_corr, val} << 1;
    assign bcd_sh     = sh_all[BCD_W+VAL_W-1:VAL_W];
    assign val_sh     = sh_all[VAL_W-1:0];
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(VAL_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap   <= '0;
            sign  <= 1'b0;
            nz    <= 1'b0;
            val   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            dig_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) cap <= tx10;
                LOAD: begin
                    sign <= cap[WIDTH_IN-1];
                    val  <= val_ld;
                    nz   <= |val_ld;
                    bcd  <= '0;
                    cnt  <= '0;
                end
                SHIFT: begin
                    bcd <= bcd_sh;
                    val <= val_sh;
                    cnt <= cnt + 1'b1;
                    // Result lands on the edge into DONE so it is visible with the pulse.
                    if (last_shift) begin
                        dig_q <= bcd_sh;
                        neg_q <= sign & nz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign neg  = neg_q;
    assign d3   = dig_q[15:12];
    assign d2   = dig_q[11:8];
    assign d1   = dig_q[7:4];
    assign d0   = dig_q[3:0];

endmodule

// File: tb/tb_tx10_bcd_display.sv
// Directed bench for tx10_bcd_display: expected results queued at start, checked on done.
module tb_tx10_bcd_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [16:0] tx10 = '0;
    logic        busy, done, neg;
    logic [3:0]  d3, d2, d1, d0;

    typedef struct packed {
        logic        neg;
        logic [15:0] dig;
    } exp_t;

    exp_t sb[$];
    int   done_at[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   n0;

    tx10_bcd_display dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .tx10  (tx10),
        .busy  (busy),
        .done  (done),
        .neg   (neg),
        .d3    (d3),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic n, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d);
        exp_t e;
        e.neg = n;
        e.dig = {a, b, c, d};
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            done_at.push_back(cyc);
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", {15'd0, neg, d3, d2, d1, d0}, {15'd0, e});
            end
        end
    end

    // One conversion with the latency and busy/idle boundaries checked around it.
    task automatic conv(input logic [16:0] v, input exp_t e);
        @(negedge clk);
        tx10  = v;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_load", 32'(busy), 32'd1);
        repeat (13) @(posedge clk);
        #1 chk("done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1 chk("latency", 32'(done), 32'd1);
        @(posedge clk);
        #1 chk("idle_after", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", {15'd0, neg, d3, d2, d1, d0}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        conv(17'd4000,    mk(1'b0, 4'd0, 4'd2, 4'd5, 4'd0));
        conv(17'h1F970,   mk(1'b1, 4'd0, 4'd1, 4'd0, 4'd5));
        conv(17'd33920,   mk(1'b0, 4'd2, 4'd1, 4'd2, 4'd0));
        conv(17'd5120,    mk(1'b0, 4'd0, 4'd3, 4'd2, 4'd0));
        conv(17'd15,      mk(1'b0, 4'd0, 4'd0, 4'd0, 4'd1));
        conv(17'd7,       mk(1'b0, 4'd0, 4'd0, 4'd0, 4'd0));
        conv(17'h1FFF9,   mk(1'b0, 4'd0, 4'd0, 4'd0, 4'd0));
        conv(17'h10000,   mk(1'b1, 4'd4, 4'd0, 4'd9, 4'd6));

        // start while busy and a tx10 change after capture must not disturb the result
        n0 = done_cnt;
        @(negedge clk);
        tx10  = 17'd5120;
        start = 1'b1;
        sb.push_back(mk(1'b0, 4'd0, 4'd3, 4'd2, 4'd0));
        @(posedge clk);
        #1 start = 1'b0;
        tx10 = 17'h1F970;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tx10  = 17'd15;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (25) @(posedge clk);
        #1 chk("busy_single_done", 32'(done_cnt - n0), 32'd1);

        // start held high: three back-to-back conversions
        done_at.delete();
        repeat (3) sb.push_back(mk(1'b0, 4'd2, 4'd1, 4'd2, 4'd0));
        @(negedge clk);
        tx10  = 17'd33920;
        start = 1'b1;
        @(posedge clk);
        repeat (32) @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("b2b_count", 32'(done_at.size()), 32'd3);
        if (done_at.size() == 3) begin
            chk("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'd16);
            chk("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'd16);
        end

        // reset mid-SHIFT abandons the conversion
        n0 = done_cnt;
        @(negedge clk);
        tx10  = 17'd4000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_out", {15'd0, neg, d3, d2, d1, d0}, 32'd0);
        repeat (20) @(posedge clk);
        #1 chk("midrst_no_done", 32'(done_cnt - n0), 32'd0);

        conv(17'h1F970, mk(1'b1, 4'd0, 4'd1, 4'd0, 4'd5));

        repeat (3) @(posedge clk);
        #1 chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx10_bcd_display.md
Name: tx10_bcd_display

Overview:
Sequential binary-to-BCD converter. It consumes the signed temperature×10 word from the temperature conversion stage (Celsius or Fahrenheit, 4 fractional bits). It produces a sign flag and four BCD digits, e.g. 25.3 is shown as 0,2,5,3 with the decimal point fixed before d0. It sits between the conversion stage and the seven-segment display driver, and uses an iterative shift-add-3 (double-dabble) loop to keep area small.

Parameters:
WIDTH_IN, 17, width of the signed tx10 input word
FRAC_BITS, 4, fractional bits dropped (after rounding) from the input
DIGITS, 4, number of BCD output digits

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request conversion of tx10; sampled only in IDLE
tx10  input  17  signed two's-complement temperature×10, Q12.4
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; outputs updated in the same cycle
neg  output  1  result is negative
d3  output  4  BCD thousands digit (tens of degrees ×10 scale)
d2  output  4  BCD hundreds digit
d1  output  4  BCD tens digit
d0  output  4  BCD ones digit (tenths of a degree)

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; busy=0, done=0, neg=0, d3..d0=0. Any in-flight conversion is abandoned and no done pulse is produced.
- States:
  - IDLE: start=1 → LOAD; tx10 is captured into an internal register.
  - LOAD: 1 cycle, then → SHIFT.
  - SHIFT: 13 cycles (WIDTH_IN-FRAC_BITS), then → DONE.
  - DONE: 1 cycle, then → IDLE unconditionally.
- LOAD arithmetic:
  - sign = captured[16].
  - mag = sign ? (0 - captured) : captured, computed 18 bits wide.
  - value = (mag + 8) >> 4 (round half up on magnitude, 14 bits).
  - Max value is 4096, so no overflow is possible.
- SHIFT:
  - Each cycle, every BCD nibble ≥5 gets +3, then {bcd, value} shifts left by 1.
  - value is held in 13 bits; LOAD saturates it at 8191.
- DONE:
  - d3..d0 take the BCD register.
  - neg = sign AND (value != 0), so negative zero displays as positive.
  - done=1 for exactly this cycle.
- Latency: start sampled at edge N → done high in cycle N+15.
- Outputs hold their last result until the next DONE or reset.
- start while busy (LOAD, SHIFT, DONE) is ignored; there is no queueing.
- A change on tx10 after the capture edge does not affect the result in flight.
- start held high continuously yields back-to-back conversions every 16 cycles (IDLE → LOAD → 13×SHIFT → DONE).
- Input 0x10000 (most negative) gives mag 65536 → value 4096 → digits 4,0,9,6, neg=1.

Decomposition:
- Package tx10_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - constants TX10_W=17, TX10_FRAC=4, BCD_DIGITS=4, SHIFT_CYCLES=13
- One sub-module, bcd_add3: combinational 4-bit "if ≥5 add 3" correction, instantiated once per digit.

Test Plan:
- Reset → outputs zero, busy=0. tx10=4000 (25.0 C), start → done at +15 cycles; neg=0, digits 0,2,5,0.
- tx10=0x1F970 (−1680, −10.5 C) → neg=1, digits 0,1,0,5.
- tx10=33920 (212.0 F, i.e. 100 C) → neg=0, digits 2,1,2,0. tx10=5120 (32.0 F) → 0,3,2,0.
- Rounding:
  - tx10=15 → 0,0,0,1.
  - tx10=7 → 0,0,0,0.
  - tx10=0x1FFF9 (−7) → digits 0,0,0,0 with neg=0 (no negative zero).
  - tx10=0x10000 → 4,0,9,6, neg=1.
- Busy handling: start pulsed again at +3 cycles with a different tx10 → ignored, single done, first result only. Start held high → done pulses spaced 16 cycles apart.
- rst_n=0 for one cycle mid-SHIFT (+7) → no done pulse; outputs zero, state IDLE. A new start then converts correctly.
